// File: rtl/vga_screen_arbiter_if.sv
// Screen-arbiter bus: per-screen requests and VGA vsync in, mux select and status out.
// The game controller side is the master; the arbiter is the slave.
interface vga_screen_arbiter_if #(
    parameter int NUM_SCREENS = 6,
    parameter int IDX_W       = 3,
    parameter int CNT_W       = 16
);
    logic [NUM_SCREENS-1:0] req;
    logic                   vga_vs;
    logic [NUM_SCREENS-1:0] sel;
    logic [IDX_W-1:0]       sel_idx;
    logic                   active;
    logic                   switch_pending;
    logic                   screen_changed;
    logic [CNT_W-1:0]       frames_shown;

    modport master (
        output req,
        output vga_vs,
        input  sel,
        input  sel_idx,
        input  active,
        input  switch_pending,
        input  screen_changed,
        input  frames_shown
    );

    modport slave (
        input  req,
        input  vga_vs,
        output sel,
        output sel_idx,
        output active,
        output switch_pending,
        output screen_changed,
        output frames_shown
    );
endinterface

// File: rtl/vga_screen_arbiter.sv
// Fixed-priority full-screen source arbiter for the VGA output mux.
// Source changes happen only on a vsync fall, with optional black frames between screens.
module vga_screen_arbiter #(
    parameter int NUM_SCREENS  = 6,
    parameter int IDX_W        = 3,
    parameter int BLANK_FRAMES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    vga_screen_arbiter_if.slave  bus
);

    // state    | meaning
    // ST_BLACK | nothing routed, waiting for a request at a frame boundary
    // ST_SHOW  | screen r_cur routed to the output, counting frames
    // ST_BLANK | forced black between two screens, r_blank_cnt frames left
    typedef enum logic [1:0] {
        ST_BLACK = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_vs_meta;
    logic                   r_vs_sync;
    logic                   r_vs_prev;
    logic [IDX_W-1:0]       r_cur;
    logic [NUM_SCREENS-1:0] r_sel;
    logic                   r_active;
    logic                   r_changed;
    logic [CNT_W-1:0]       r_frames;
    logic [7:0]             r_blank_cnt;

    logic                   w_frame_tick;
    logic [IDX_W-1:0]       w_target;
    logic                   w_target_valid;
    logic [NUM_SCREENS-1:0] w_target_onehot;
    logic                   w_pending;

    // Idle level of vsync is high, so the synchronizer resets high to avoid a false tick.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_vs_meta <= 1'b1;
            r_vs_sync <= 1'b1;
            r_vs_prev <= 1'b1;
        end else begin
            r_vs_meta <= bus.vga_vs;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
        end
    end

    assign w_frame_tick = r_vs_prev & ~r_vs_sync;

    always_comb begin
        w_target = '0;
        for (int i = NUM_SCREENS - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                w_target = IDX_W'(i);
            end
        end
    end

    assign w_target_valid  = |bus.req;
    assign w_target_onehot = NUM_SCREENS'(1) << w_target;

    always_comb begin
        w_pending = 1'b0;
        case (r_state)
            ST_BLACK: w_pending = w_target_valid;
            ST_SHOW:  w_pending = !w_target_valid || (w_target != r_cur);
            ST_BLANK: w_pending = 1'b1;
            default:  w_pending = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_BLACK;
            r_cur       <= '0;
            r_sel       <= '0;
            r_active    <= 1'b0;
            r_changed   <= 1'b0;
            r_frames    <= '0;
            r_blank_cnt <= '0;
        end else begin
            r_changed <= 1'b0;
            case (r_state)
                ST_BLACK: begin
                    if (w_frame_tick && w_target_valid) begin
                        r_state   <= ST_SHOW;
                        r_cur     <= w_target;
                        r_sel     <= w_target_onehot;
                        r_active  <= 1'b1;
                        r_changed <= 1'b1;
                        r_frames  <= '0;
                    end
                end

                ST_SHOW: begin
                    if (w_frame_tick) begin
                        if (w_pending) begin
                            if (BLANK_FRAMES == 0) begin
                                if (w_target_valid) begin
                                    r_cur     <= w_target;
                                    r_sel     <= w_target_onehot;
                                    r_changed <= 1'b1;
                                    r_frames  <= '0;
                                end else begin
                                    r_state  <= ST_BLACK;
                                    r_sel    <= '0;
                                    r_active <= 1'b0;
                                end
                            end else begin
                                r_state     <= ST_BLANK;
                                r_blank_cnt <= 8'(BLANK_FRAMES);
                                r_sel       <= '0;
                                r_active    <= 1'b0;
                            end
                        end else if (r_frames != '1) begin
                            r_frames <= r_frames + CNT_W'(1);
                        end
                    end
                end

                ST_BLANK: begin
                    // The request is re-resolved only on the last blank tick.
                    if (w_frame_tick) begin
                        if (r_blank_cnt <= 8'd1) begin
                            r_blank_cnt <= '0;
                            if (w_target_valid) begin
                                r_state   <= ST_SHOW;
                                r_cur     <= w_target;
                                r_sel     <= w_target_onehot;
                                r_active  <= 1'b1;
                                r_changed <= 1'b1;
                                r_frames  <= '0;
                            end else begin
                                r_state <= ST_BLACK;
                            end
                        end else begin
                            r_blank_cnt <= r_blank_cnt - 8'd1;
                        end
                    end
                end

                default: begin
                    r_state  <= ST_BLACK;
                    r_sel    <= '0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel            = r_sel;
    assign bus.sel_idx        = r_cur;
    assign bus.active         = r_active;
    assign bus.switch_pending = w_pending;
    assign bus.screen_changed = r_changed;
    assign bus.frames_shown   = r_frames;

endmodule
